// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [3:0] BCD_ADJ    = 4'd3;
  localparam logic [3:0] BCD_THRESH = 4'd5;

  // Decimal digits needed for any bin_w-bit unsigned value: ceil(bin_w * log10(2)).
  function automatic int min_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= BCD_THRESH) ? (digit + BCD_ADJ) : digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, sign on neg.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  busy
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                  neg
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  // Only a digit count too small for BIN_W can ever push a one out of the top digit.
  localparam bit NARROW = (DIGITS < min_digits(BIN_W));

  state_t               state;
  logic [BIN_W-1:0]     shreg;
  logic [CNT_W-1:0]     count;
  logic [4*DIGITS-1:0]  adj;
  logic [4*DIGITS-1:0]  acc_next;
  logic [BIN_W-1:0]     capture;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd[4*i +: 4]),
      .adjusted (adj[4*i +: 4])
    );
  end

  assign acc_next = {adj[4*DIGITS-2:0], shreg[BIN_W-1]};

`ifdef BIN2BCD_SIGNED_EN
  logic sign;

  // Negating the most negative value wraps to 2^(BIN_W-1), which is exact as unsigned.
  always_comb begin
    capture = binary;
    if (binary[BIN_W-1]) begin
      capture = ~binary + 1'b1;
    end
  end
`else
  assign capture = binary;
`endif

  // Single FSM: bcd doubles as the accumulator and is frozen once DONE is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      count     <= '0;
      bcd       <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
      sign      <= 1'b0;
      neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= capture;
            bcd      <= '0;
            overflow <= 1'b0;
            count    <= CNT_W'(BIN_W);
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= SHIFT;
`ifdef BIN2BCD_SIGNED_EN
            sign     <= binary[BIN_W-1];
`endif
          end
        end

        SHIFT: begin
          bcd   <= acc_next;
          shreg <= shreg << 1;
          count <= count - 1'b1;
          if (NARROW && adj[4*DIGITS-1]) begin
            overflow <= 1'b1;
          end
          if (count == CNT_W'(1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef BIN2BCD_SIGNED_EN
            neg       <= sign;
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef BIN2BCD_SIGNED_EN
            neg       <= 1'b0;
`endif
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
